// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Frames go out LSB-first; back-to-back bytes leave no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_wdata,
    input  logic                          tx_wstrb,
    output logic                          tx_full,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_overflow,
    output logic                          ftdi_txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          push;
    logic          pop;
    logic          has_data;

    assign has_data = (level_q != '0);
    assign push     = tx_wstrb & ~full_q;

    // Transmit FSM: next state, baud counting, shift/pop control and line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr_q];
                    state_d = START;
                    cnt_d   = CNT_MAX;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    cnt_d   = CNT_MAX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = CNT_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (has_data) begin
                        pop     = 1'b1;
                        shift_d = mem[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping; a same-edge pop never makes room for the write.
    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ovf_d  = ovf_q | (tx_wstrb & full_q);
        full_d = (level_d == LVL_FULL);
        busy_d = (state_d != IDLE) || (level_d != '0);
    end

    // State, pointers and status flags, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // Byte storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= tx_wdata;
        end
    end

    assign ftdi_txd    = txd_q;
    assign tx_full     = full_q;
    assign tx_busy     = busy_q;
    assign tx_level    = level_q;
    assign tx_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic,
// checked each cycle against a frame-level queue model and a line decoder.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FR    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_wdata = 8'h00;
    logic       tx_wstrb = 1'b0;
    logic       tx_full;
    logic       tx_busy;
    logic [2:0] tx_level;
    logic       tx_overflow;
    logic       ftdi_txd;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_wdata   (tx_wdata),
        .tx_wstrb   (tx_wstrb),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy),
        .tx_level   (tx_level),
        .tx_overflow(tx_overflow),
        .ftdi_txd   (ftdi_txd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    logic [7:0] dec_q[$];
    logic [7:0] cur = 8'h00;
    int         frame_left = 0;
    logic       m_txd = 1'b1;
    logic       m_ovf = 1'b0;

    int         mon_on = 0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic step(input logic r, input logic s, input logic [7:0] d);
        int   pre;
        logic nxt;
        logic [7:0] exp_b;
        rst      = r;
        tx_wstrb = s;
        tx_wdata = d;
        if (r) begin
            q.delete();
            dec_q.delete();
            frame_left = 0;
            m_txd      = 1'b1;
            m_ovf      = 1'b0;
        end else begin
            pre = q.size();
            nxt = (frame_left > 0) ? line_bit(cur, (FR - frame_left) / CPB) : 1'b1;
            if (pre > 0 && frame_left <= 1) begin
                cur = q.pop_front();
                dec_q.push_back(cur);
                frame_left = FR;
            end else if (frame_left > 0) begin
                frame_left--;
            end
            if (s) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else q.push_back(d);
            end
            m_txd = nxt;
        end
        @(posedge clk);
        #1;
        check("txd", 32'(ftdi_txd), 32'(m_txd));
        check("busy", 32'(tx_busy), 32'(frame_left > 0 || q.size() > 0));
        check("level", 32'(tx_level), 32'(q.size()));
        check("full", 32'(tx_full), 32'(q.size() == DEPTH));
        check("ovf", 32'(tx_overflow), 32'(m_ovf));
        if (r) begin
            mon_on  = 0;
            mon_cnt = 0;
        end else if (mon_on == 0) begin
            if (ftdi_txd == 1'b0) begin
                mon_on  = 1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            for (int i = 0; i < 8; i++)
                if (mon_cnt == CPB + i * CPB + CPB / 2) mon_byte[i] = ftdi_txd;
            if (mon_cnt == 9 * CPB + CPB / 2) begin
                check("stopbit", 32'(ftdi_txd), 32'd1);
                check("dec_avail", 32'(dec_q.size() != 0), 32'd1);
                exp_b = (dec_q.size() != 0) ? dec_q.pop_front() : 8'h00;
                check("dec_byte", 32'(mon_byte), 32'(exp_b));
                mon_on = 0;
            end
        end
        tx_wstrb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);

        idle(1000);

        step(1'b0, 1'b1, 8'h55);
        k = 0;
        do begin
            step(1'b0, 1'b0, 8'h00);
            k++;
        end while (ftdi_txd && k < 10);
        check("t1_latency", 32'(k), 32'd2);
        idle(60);

        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h3C);
        idle(100);

        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
        check("t3_ovf", 32'(tx_overflow), 32'd1);
        check("t3_level", 32'(tx_level), 32'd4);
        idle(250);

        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h40 + i));
        for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 8'($urandom));
        idle(250);

        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        idle(15);
        step(1'b1, 1'b0, 8'h00);
        check("t5_txd", 32'(ftdi_txd), 32'd1);
        check("t5_level", 32'(tx_level), 32'd0);
        idle(200);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1999) == 0)
                step(1'b1, 1'b0, 8'h00);
            else
                step(1'b0, $urandom_range(19) == 0, 8'($urandom));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom));
        idle(300);
        check("undecoded", 32'(dec_q.size()), 32'd0);
        check("end_busy", 32'(tx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
